fill_engine: RTL and testbench

FILL_ENGINE -- requirements
Module: fill_engine

---
 rtl/fill_engine.sv | 125 ++++++++++++
 tb/tb_fill_engine.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fill_engine.sv
// fill_engine: per-row read-merge-write of a fill color into an SRAM pixel span,
// driven by one coverage mask per row (contiguous SPAN fill or per-pixel MASK fill).
module fill_engine #(
    parameter int PIX_BITS     = 24,
    parameter int SPAN_PIX     = 64,
    parameter int NUM_ROWS     = 64,
    parameter int ADDR_BITS    = 24,
    parameter int ROW_STRIDE   = 256,
    parameter int LAYER_STRIDE = 65536,
    parameter int LAYER_BITS   = 1,
    localparam int CNT_BITS    = $clog2(NUM_ROWS + 1),
    localparam int DATA_BITS   = PIX_BITS * SPAN_PIX
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  mode,
    input  logic [7:0]            x0,
    input  logic [7:0]            y0,
    input  logic [LAYER_BITS-1:0] layer,
    input  logic [CNT_BITS-1:0]   row_count,
    input  logic [PIX_BITS-1:0]   color,
    input  logic                  mask_valid,
    input  logic [SPAN_PIX-1:0]   mask,
    output logic                  mask_ready,
    output logic                  read_enable,
    output logic                  write_enable,
    output logic [ADDR_BITS-1:0]  address,
    input  logic [DATA_BITS-1:0]  read_data,
    output logic [DATA_BITS-1:0]  write_data,
    input  logic                  mem_ack,
    output logic                  busy,
    output logic                  row_done,
    output logic                  done
);
    typedef enum logic [2:0] {IDLE, WAIT_MASK, READ, MERGE, WRITE, NEXT, DONE} state_t;

    state_t                 state, state_nx;
    logic                   mode_q;
    logic [PIX_BITS-1:0]    color_q;
    logic [CNT_BITS-1:0]    rows_q, row_idx, rows_in;
    logic [SPAN_PIX-1:0]    mask_q, below, above, sel;
    logic [ADDR_BITS-1:0]   base, row_addr;
    logic [DATA_BITS-1:0]   merged;
    logic                   last_row;

    assign base = ADDR_BITS'(layer) * ADDR_BITS'(LAYER_STRIDE)
                + ADDR_BITS'(y0) * ADDR_BITS'(ROW_STRIDE) + ADDR_BITS'(x0);
    assign rows_in  = row_count > CNT_BITS'(NUM_ROWS) ? CNT_BITS'(NUM_ROWS) : row_count;
    assign last_row = row_idx + CNT_BITS'(1) == rows_q;
    assign address  = row_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (start) state_nx = rows_in == '0 ? DONE : WAIT_MASK;
            WAIT_MASK: if (mask_valid) state_nx = |mask ? READ : NEXT;
            READ:      if (mem_ack) state_nx = MERGE;
            MERGE:     state_nx = WRITE;
            WRITE:     if (mem_ack) state_nx = NEXT;
            NEXT:      state_nx = last_row ? DONE : WAIT_MASK;
            DONE:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
        if (abort && state != IDLE) state_nx = IDLE;
        busy         = state != IDLE;
        mask_ready   = state == WAIT_MASK;
        read_enable  = state == READ;
        write_enable = state == WRITE;
        row_done     = state == NEXT && !abort;
        done         = state == DONE && !abort;
    end

    // SPAN coverage: a pixel is filled when some mask bit is set at or below it and at or above it
    always_comb begin
        logic lo_seen, hi_seen;
        lo_seen = 1'b0;
        hi_seen = 1'b0;
        below   = '0;
        above   = '0;
        for (int k = 0; k < SPAN_PIX; k++) begin
            lo_seen = lo_seen | mask_q[k];
            hi_seen = hi_seen | mask_q[SPAN_PIX-1-k];
            below[k] = lo_seen;
            above[SPAN_PIX-1-k] = hi_seen;
        end
        sel    = mode_q ? mask_q : below & above;
        merged = read_data;
        for (int k = 0; k < SPAN_PIX; k++)
            if (sel[k]) merged[k*PIX_BITS +: PIX_BITS] = color_q;
    end

    // The merged word is latched as read data is accepted and held through MERGE and WRITE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q     <= 1'b0;
            color_q    <= '0;
            rows_q     <= '0;
            row_idx    <= '0;
            mask_q     <= '0;
            row_addr   <= '0;
            write_data <= '0;
        end else begin
            if (state == IDLE && start) begin
                mode_q   <= mode;
                color_q  <= color;
                rows_q   <= rows_in;
                row_addr <= base;
                row_idx  <= '0;
            end
            if (state == WAIT_MASK && mask_valid) mask_q <= mask;
            if (state == READ && mem_ack && !abort) write_data <= merged;
            if (state == NEXT && !abort) begin
                row_addr <= row_addr + ADDR_BITS'(ROW_STRIDE);
                row_idx  <= row_idx + CNT_BITS'(1);
            end
        end
    end
endmodule

// File: tb/tb_fill_engine.sv
// tb_fill_engine: table vectors, hand-built abort/reset/latency sequences and random jobs
// checked against a pixel-level model of the fill rules and a behavioural SRAM.
module tb_fill_engine;
    localparam int W = 24 * 64;

    logic         clk = 1'b0, rst = 1'b1;
    logic         start = 1'b0, abort = 1'b0, mode = 1'b0;
    logic [7:0]   x0 = '0, y0 = '0;
    logic [0:0]   layer = '0;
    logic [6:0]   row_count = '0;
    logic [23:0]  color = '0;
    logic         mask_valid = 1'b0;
    logic [63:0]  mask = '0;
    logic         mask_ready, read_enable, write_enable, busy, row_done, done;
    logic [23:0]  address;
    logic [W-1:0] read_data = '0, write_data;
    logic         mem_ack = 1'b0;

    always #5 clk = ~clk;

    fill_engine dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
        .x0(x0), .y0(y0), .layer(layer), .row_count(row_count), .color(color),
        .mask_valid(mask_valid), .mask(mask), .mask_ready(mask_ready),
        .read_enable(read_enable), .write_enable(write_enable), .address(address),
        .read_data(read_data), .write_data(write_data), .mem_ack(mem_ack),
        .busy(busy), .row_done(row_done), .done(done)
    );

    typedef struct {
        bit md; bit ly; bit [7:0] x; bit [7:0] y; bit [6:0] rc; bit [23:0] col;
        bit [63:0] m0; bit [63:0] m1; bit [63:0] m2;
        bit [23:0] ea; bit [63:0] ep; int ewr; int erd; int ebusy;
    } vec_t;
    vec_t tv[8];

    int errors = 0, checks = 0;
    bit j_mode, j_layer;
    bit [7:0] j_x0, j_y0;
    bit [6:0] j_rows;
    bit [23:0] j_color;
    bit [63:0] jm[64];
    bit [W-1:0] mem[int];
    bit [W-1:0] ref_mem[int];
    int n_rd, n_wr, n_rdcyc, n_rowdone, n_done, n_busy, n_mready, gap, proto_bad;
    bit timed_out, idle_busy;
    bit [23:0] first_waddr;
    bit [W-1:0] first_wdata;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int rows_eff();
        return j_rows > 7'd64 ? 64 : int'(j_rows);
    endfunction

    function automatic int row_addr_of(input int r);
        return (int'(j_layer) * 65536 + int'(j_y0) * 256 + int'(j_x0) + r * 256) & 32'hFFFFFF;
    endfunction

    function automatic bit [W-1:0] rnd_word();
        bit [W-1:0] w;
        for (int i = 0; i < W / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Reference fill: SPAN covers lowest..highest set bit, MASK covers set bits only
    function automatic bit [W-1:0] model_fill(input bit [W-1:0] old, input bit [63:0] m);
        int lo = -1, hi = -1;
        for (int k = 0; k < 64; k++) if (m[k]) begin
            if (lo < 0) lo = k;
            hi = k;
        end
        for (int k = 0; k < 64; k++)
            if (j_mode ? m[k] : (lo >= 0 && k >= lo && k <= hi)) old[k*24 +: 24] = j_color;
        return old;
    endfunction

    task automatic prepare(input bit zero);
        bit [W-1:0] w;
        mem.delete();
        ref_mem.delete();
        for (int r = 0; r < rows_eff(); r++) begin
            w = zero ? '0 : rnd_word();
            mem[row_addr_of(r)] = w;
            ref_mem[row_addr_of(r)] = jm[r] != 0 ? model_fill(w, jm[r]) : w;
        end
    endtask

    task automatic drive_job();
        start = 1'b1; mode = j_mode; layer = j_layer; x0 = j_x0; y0 = j_y0;
        row_count = j_rows; color = j_color; mask_valid = 1'b0; mem_ack = 1'b0; abort = 1'b0;
    endtask

    task automatic run_job(input int dmin, input int dmax, input bit noisy);
        int rowi = 0, mwait, cnt = 0, cur;
        bit prev_rd = 0, prev_wr = 0, gap_on = 0, got_done = 0;
        bit [W-1:0] prev_wd = '0;
        n_rd = 0; n_wr = 0; n_rdcyc = 0; n_rowdone = 0; n_done = 0; n_busy = 0;
        n_mready = 0; gap = 0; proto_bad = 0; first_waddr = '0; first_wdata = '0;
        @(negedge clk);
        drive_job();
        mwait = noisy ? $urandom_range(0, 2) : 0;
        for (int cyc = 0; cyc < 6000 && !got_done; cyc++) begin
            @(negedge clk);
            if (busy) n_busy++;
            if (row_done) n_rowdone++;
            if (mask_ready) n_mready++;
            if (done) begin n_done++; got_done = 1; end
            if (read_enable && write_enable) proto_bad++;
            cur = rowi - 1;
            if ((read_enable || write_enable) &&
                (cur < 0 || cur >= 64 || jm[cur] == 0 || int'(address) != row_addr_of(cur))) proto_bad++;
            if (gap_on) begin
                gap++;
                if (write_enable) gap_on = 0;
            end
            start = noisy ? 1'($urandom) : 1'b0;
            if (noisy) begin
                mode = 1'($urandom); layer = 1'($urandom); x0 = 8'($urandom); y0 = 8'($urandom);
                row_count = 7'($urandom); color = 24'($urandom);
            end
            if (mask_ready && mwait > 0) begin
                mwait--; mask_valid = 1'b0; mask = {$urandom, $urandom};
            end else if (mask_ready) begin
                mask_valid = 1'b1; mask = rowi < 64 ? jm[rowi] : 64'h0; rowi++;
                mwait = noisy ? $urandom_range(0, 2) : 0;
            end else begin
                mask_valid = noisy ? 1'($urandom) : 1'b0; mask = {$urandom, $urandom};
            end
            if (read_enable && !write_enable) begin
                n_rdcyc++;
                if (!prev_rd) cnt = $urandom_range(dmin, dmax);
                if (cnt == 0) begin
                    mem_ack = 1'b1;
                    read_data = mem.exists(int'(address)) ? mem[int'(address)] : '0;
                    n_rd++; gap = 0; gap_on = 1;
                end else begin
                    cnt--; mem_ack = 1'b0; read_data = rnd_word();
                end
            end else if (write_enable && !read_enable) begin
                if (prev_wr && write_data != prev_wd) proto_bad++;
                prev_wd = write_data;
                if (!prev_wr) cnt = $urandom_range(dmin, dmax);
                if (cnt == 0) begin
                    mem_ack = 1'b1; mem[int'(address)] = write_data; n_wr++;
                    if (n_wr == 1) begin first_waddr = address; first_wdata = write_data; end
                end else begin
                    cnt--; mem_ack = 1'b0;
                end
            end else begin
                mem_ack = noisy ? 1'($urandom) : 1'b0; read_data = rnd_word();
            end
            prev_rd = read_enable;
            prev_wr = write_enable;
            if (got_done) begin start = 1'b0; mask_valid = 1'b0; mem_ack = 1'b0; end
        end
        timed_out = !got_done;
        start = 1'b0; mask_valid = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        idle_busy = busy;
    endtask

    task automatic job_checks(input string tag);
        int exp_wr = 0, bad = 0;
        for (int r = 0; r < rows_eff(); r++) if (jm[r] != 0) exp_wr++;
        foreach (ref_mem[a]) if (mem[a] != ref_mem[a]) bad++;
        chk({tag, "_timeout"}, longint'(timed_out), 0);
        chk({tag, "_done_pulses"}, n_done, 1);
        chk({tag, "_row_done_pulses"}, n_rowdone, rows_eff());
        chk({tag, "_writes"}, n_wr, exp_wr);
        chk({tag, "_reads"}, n_rd, exp_wr);
        chk({tag, "_protocol_errs"}, proto_bad, 0);
        chk({tag, "_busy_after"}, longint'(idle_busy), 0);
        chk({tag, "_bad_rows"}, bad, 0);
    endtask

    task automatic clear_masks();
        for (int r = 0; r < 64; r++) jm[r] = '0;
    endtask

    initial begin
        bit [W-1:0] ew;
        bit hit, stray;
        tv[0] = '{1'b0, 1'b1, 8'd16, 8'd8, 7'd1, 24'hFF0000, 64'h810, 64'h0, 64'h0, 24'h010810, 64'hFF0, 1, 1, 6};
        tv[1] = '{1'b1, 1'b1, 8'd16, 8'd8, 7'd1, 24'hFF0000, 64'h810, 64'h0, 64'h0, 24'h010810, 64'h810, 1, 1, 6};
        tv[2] = '{1'b0, 1'b0, 8'd0, 8'd0, 7'd3, 24'h123456, 64'h0, 64'h1, 64'h0, 24'h000100, 64'h1, 1, 3, 10};
        tv[3] = '{1'b0, 1'b0, 8'd0, 8'd0, 7'd0, 24'h777777, 64'h5, 64'h0, 64'h0, 24'h000000, 64'h0, 0, 0, 1};
        tv[4] = '{1'b0, 1'b0, 8'd3, 8'd2, 7'd1, 24'hABCDEF, 64'h8000000000000000, 64'h0, 64'h0,
                  24'h000203, 64'h8000000000000000, 1, 1, 6};
        tv[5] = '{1'b0, 1'b1, 8'd255, 8'd255, 7'd1, 24'h00FF00, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h0,
                  24'h01FFFF, 64'hFFFFFFFFFFFFFFFF, 1, 1, 6};
        tv[6] = '{1'b0, 1'b0, 8'd1, 8'd1, 7'd100, 24'h0000FF, 64'h0, 64'h0, 64'h0, 24'h000000, 64'h0, 0, 64, 129};
        tv[7] = '{1'b0, 1'b0, 8'd0, 8'd0, 7'd2, 24'h00ABCD, 64'h40100400, 64'h0, 64'h0,
                  24'h000000, 64'h7FFFFC00, 1, 2, 8};

        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_row_done", row_done, 0);
        chk("reset_mask_ready", mask_ready, 0);
        chk("reset_read_enable", read_enable, 0);
        chk("reset_write_enable", write_enable, 0);
        chk("reset_address", address, 0);
        chk("reset_write_data_nonzero", longint'(|write_data), 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            j_mode = tv[i].md; j_layer = tv[i].ly; j_x0 = tv[i].x; j_y0 = tv[i].y;
            j_rows = tv[i].rc; j_color = tv[i].col;
            clear_masks();
            jm[0] = tv[i].m0; jm[1] = tv[i].m1; jm[2] = tv[i].m2;
            prepare(1'b1);
            run_job(0, 0, 1'b0);
            job_checks($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_tbl_writes", i), n_wr, tv[i].ewr);
            chk($sformatf("vec%0d_tbl_row_done", i), n_rowdone, tv[i].erd);
            chk($sformatf("vec%0d_tbl_mask_ready_cycles", i), n_mready, tv[i].erd);
            chk($sformatf("vec%0d_tbl_busy_cycles", i), n_busy, tv[i].ebusy);
            if (tv[i].ewr > 0) begin
                ew = '0;
                for (int k = 0; k < 64; k++) if (tv[i].ep[k]) ew[k*24 +: 24] = tv[i].col;
                chk($sformatf("vec%0d_write_addr", i), first_waddr, tv[i].ea);
                chk($sformatf("vec%0d_write_data_ok", i), longint'(first_wdata == ew), 1);
            end
        end

        // Slow memory: read held 5 cycles, write must follow the merge cycle directly
        j_mode = 1'b0; j_layer = 1'b0; j_x0 = 8'd5; j_y0 = 8'd1; j_rows = 7'd1; j_color = 24'h3C3C3C;
        clear_masks(); jm[0] = 64'hF0;
        prepare(1'b0);
        run_job(5, 5, 1'b0);
        job_checks("slow_read");
        chk("slow_read_enable_cycles", n_rdcyc, 6);
        chk("slow_read_ack_to_write", gap, 2);

        // Abort in WRITE together with mem_ack
        j_mode = 1'b0; j_layer = 1'b0; j_x0 = 8'd0; j_y0 = 8'd4; j_rows = 7'd2; j_color = 24'h0000FF;
        clear_masks(); jm[0] = 64'h3; jm[1] = 64'h5;
        @(negedge clk);
        drive_job();
        hit = 0; stray = 0;
        for (int c = 0; c < 30 && !hit; c++) begin
            @(negedge clk);
            start = 1'b0; mem_ack = 1'b0; mask_valid = 1'b0;
            if (row_done || done) stray = 1;
            if (mask_ready) begin mask_valid = 1'b1; mask = jm[0]; end
            if (read_enable) begin mem_ack = 1'b1; read_data = '0; end
            if (write_enable) begin mem_ack = 1'b1; abort = 1'b1; hit = 1; end
        end
        chk("abort_reached_write", longint'(hit), 1);
        @(negedge clk);
        abort = 1'b0; mem_ack = 1'b0;
        chk("abort_busy_next", busy, 0);
        chk("abort_write_enable_next", write_enable, 0);
        if (row_done || done) stray = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (row_done || done || busy) stray = 1;
        end
        chk("abort_no_pulses", longint'(stray), 0);
        prepare(1'b0);
        run_job(0, 2, 1'b0);
        job_checks("after_abort");

        // Asynchronous reset while a read is pending
        j_mode = 1'b1; j_layer = 1'b1; j_x0 = 8'd9; j_y0 = 8'd9; j_rows = 7'd3; j_color = 24'h555555;
        clear_masks(); jm[0] = 64'h1; jm[1] = 64'h2; jm[2] = 64'h4;
        @(negedge clk);
        drive_job();
        hit = 0;
        for (int c = 0; c < 30 && !hit; c++) begin
            @(negedge clk);
            start = 1'b0; mask_valid = 1'b0;
            if (mask_ready) begin mask_valid = 1'b1; mask = jm[0]; end
            if (read_enable) hit = 1;
        end
        chk("rst_reached_read", longint'(hit), 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_busy", busy, 0);
        chk("rst_async_read_enable", read_enable, 0);
        chk("rst_async_address", address, 0);
        chk("rst_async_write_data_nonzero", longint'(|write_data), 0);
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        for (int c = 0; c < 10; c++) begin
            mask_valid = 1'($urandom); mem_ack = 1'($urandom); mask = {$urandom, $urandom};
            @(negedge clk);
            if (busy || read_enable || write_enable || mask_ready) stray = 1;
        end
        mask_valid = 1'b0; mem_ack = 1'b0;
        chk("rst_no_activity_after", longint'(stray), 0);

        for (int t = 0; t < 30; t++) begin
            j_mode = 1'($urandom); j_layer = 1'($urandom); j_x0 = 8'($urandom); j_y0 = 8'($urandom);
            j_rows = 7'($urandom_range(0, 10)); j_color = 24'($urandom);
            clear_masks();
            for (int r = 0; r < 64; r++)
                case ($urandom_range(0, 3))
                    0: jm[r] = '0;
                    1: jm[r] = 64'h1 << $urandom_range(0, 63);
                    2: jm[r] = '1;
                    default: jm[r] = {$urandom, $urandom};
                endcase
            prepare(1'b0);
            run_job(0, 3, 1'b1);
            job_checks($sformatf("rand%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
